// File: rtl/cpu_state_sequencer_pkg.sv
// rtl/cpu_state_sequencer_pkg.sv - state, opcode and group encodings shared by the core sequencer
// STATE_HALT exists only when SEQ_DEBUG_HALT_EN is defined.
package cpu_state_sequencer_pkg;

   localparam int STATE_COUNT  = 3;
   localparam int OPCODE_COUNT = 6;
   localparam int GROUP_COUNT  = 8;
   localparam int SEQ_WAIT_W   = 4;

   typedef enum logic [STATE_COUNT-1:0] {
      STATE_RESET = 3'd0,
      STATE_IF    = 3'd1,
      STATE_ID    = 3'd2,
      STATE_EX    = 3'd3,
      STATE_MEM   = 3'd4,
      STATE_WB    = 3'd5
`ifdef SEQ_DEBUG_HALT_EN
      ,
      STATE_HALT  = 3'd6
`endif
   } state_e;

   localparam logic [OPCODE_COUNT-1:0] TYPE_NOP      = 6'd0;
   localparam logic [OPCODE_COUNT-1:0] TYPE_ADD      = 6'd1;
   localparam logic [OPCODE_COUNT-1:0] TYPE_LDS      = 6'd2;
   localparam logic [OPCODE_COUNT-1:0] TYPE_RJMP     = 6'd3;
   localparam logic [OPCODE_COUNT-1:0] TYPE_RET      = 6'd4;
   localparam logic [OPCODE_COUNT-1:0] TYPE_RETI     = 6'd5;
   localparam logic [OPCODE_COUNT-1:0] TYPE_RCALL    = 6'd6;
   localparam logic [OPCODE_COUNT-1:0] TYPE_CALL_ISR = 6'd7;

   localparam int GROUP_ALU      = 0;
   localparam int GROUP_MEM_RD   = 1;
   localparam int GROUP_MEM_WR   = 2;
   localparam int GROUP_IO       = 3;
   localparam int GROUP_STACK    = 4;
   localparam int GROUP_BRANCH   = 5;
   localparam int GROUP_SREG     = 6;
   localparam int GROUP_TWO_WORD = 7;

   // Stack-touching control transfers need a second MEM sub-cycle.
   function automatic logic is_two_cycle(input logic [OPCODE_COUNT-1:0] op);
      return (op == TYPE_RET) || (op == TYPE_RETI) ||
             (op == TYPE_RCALL) || (op == TYPE_CALL_ISR);
   endfunction

endpackage

// File: rtl/cpu_state_sequencer.sv
// rtl/cpu_state_sequencer.sv - multicycle IF/ID/EX/MEM/WB control FSM with interrupt entry
// Optional debug halt/step support is enabled by defining SEQ_DEBUG_HALT_EN.
module cpu_state_sequencer
   import cpu_state_sequencer_pkg::*;
#(
   parameter int RESET_WAIT_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [OPCODE_COUNT-1:0] opcode_type,
   input  logic [GROUP_COUNT-1:0]  opcode_group,
   input  logic                    irq_req,
   input  logic                    i_flag,
   output logic [STATE_COUNT-1:0]  state,
   output logic                    cycle_count,
   output logic                    ir_load,
   output logic                    pc_write,
   output logic                    isr_take,
   output logic                    retired
`ifdef SEQ_DEBUG_HALT_EN
   ,
   input  logic                    dbg_halt,
   input  logic                    dbg_step,
   output logic                    halted
`endif
);

   localparam logic [SEQ_WAIT_W-1:0] WAIT_LAST = SEQ_WAIT_W'(RESET_WAIT_CYCLES - 1);

   state_e                state_q, state_d;
   logic [SEQ_WAIT_W-1:0] wait_q, wait_d;
   logic                  cycle_q, cycle_d;
   logic                  two_cycle_q, two_cycle_d;
   logic                  reti_shadow_q, reti_shadow_d;
   logic                  isr_take_q, isr_take_d;
   logic                  irq_take;

   // Group flags are consumed by the signal generator, not by sequencing.
   logic unused_group;
   assign unused_group = ^opcode_group;

   assign irq_take = irq_req && i_flag && !reti_shadow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= STATE_RESET;
         wait_q        <= '0;
         cycle_q       <= 1'b0;
         two_cycle_q   <= 1'b0;
         reti_shadow_q <= 1'b0;
         isr_take_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         cycle_q       <= cycle_d;
         two_cycle_q   <= two_cycle_d;
         reti_shadow_q <= reti_shadow_d;
         isr_take_q    <= isr_take_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      cycle_d       = 1'b0;
      two_cycle_d   = two_cycle_q;
      reti_shadow_d = reti_shadow_q;
      isr_take_d    = isr_take_q;
      case (state_q)
         STATE_RESET: begin
            if (wait_q == WAIT_LAST) begin
               state_d = STATE_IF;
               wait_d  = '0;
            end else begin
               wait_d  = wait_q + SEQ_WAIT_W'(1);
            end
         end
         STATE_IF: state_d = STATE_ID;
         STATE_ID: state_d = STATE_EX;
         STATE_EX: begin
            state_d     = STATE_MEM;
            two_cycle_d = is_two_cycle(opcode_type);
            // Latched early so the RETI's own WB is already masked.
            if (opcode_type == TYPE_RETI) begin
               reti_shadow_d = 1'b1;
            end
         end
         STATE_MEM: begin
            if (two_cycle_q && !cycle_q) begin
               cycle_d = 1'b1;
            end else begin
               state_d = STATE_WB;
            end
         end
         STATE_WB: begin
            state_d       = STATE_IF;
            reti_shadow_d = 1'b0;
            isr_take_d    = 1'b0;
`ifdef SEQ_DEBUG_HALT_EN
            if (dbg_halt) begin
               state_d = STATE_HALT;
            end else if (irq_take) begin
               isr_take_d = 1'b1;
            end
`else
            if (irq_take) begin
               isr_take_d = 1'b1;
            end
`endif
         end
`ifdef SEQ_DEBUG_HALT_EN
         STATE_HALT: begin
            if (!dbg_halt || dbg_step) begin
               state_d = STATE_IF;
            end
         end
`endif
         default: begin
            state_d       = STATE_RESET;
            wait_d        = '0;
            two_cycle_d   = 1'b0;
            reti_shadow_d = 1'b0;
            isr_take_d    = 1'b0;
         end
      endcase
   end

   assign state       = state_q;
   assign cycle_count = cycle_q;
   assign ir_load     = (state_q == STATE_IF) && !isr_take_q;
   assign pc_write    = (state_q == STATE_WB);
   assign retired     = (state_q == STATE_WB);
   assign isr_take    = isr_take_q;
`ifdef SEQ_DEBUG_HALT_EN
   assign halted      = (state_q == STATE_HALT);
`endif

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// tb/tb_cpu_state_sequencer.sv - self-checking bench for cpu_state_sequencer
// Exercises the SEQ_DEBUG_HALT_EN ports when that macro is defined.
module tb_cpu_state_sequencer;
   import cpu_state_sequencer_pkg::*;

   localparam int W = 2;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic [OPCODE_COUNT-1:0] opcode_type = TYPE_NOP;
   logic [GROUP_COUNT-1:0]  opcode_group = '0;
   logic                    irq_req = 1'b0;
   logic                    i_flag = 1'b0;
   logic [STATE_COUNT-1:0]  state;
   logic                    cycle_count, ir_load, pc_write, isr_take, retired;
`ifdef SEQ_DEBUG_HALT_EN
   logic                    dbg_halt = 1'b0;
   logic                    dbg_step = 1'b0;
   logic                    halted;
`endif

   int   total = 0;
   int   bad = 0;
   logic inj = 1'b0;
   logic [OPCODE_COUNT-1:0] ops [7];

   always #5 clk = ~clk;

   cpu_state_sequencer #(.RESET_WAIT_CYCLES(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode_type  (opcode_type),
      .opcode_group (opcode_group),
      .irq_req      (irq_req),
      .i_flag       (i_flag),
      .state        (state),
      .cycle_count  (cycle_count),
      .ir_load      (ir_load),
      .pc_write     (pc_write),
      .isr_take     (isr_take),
      .retired      (retired)
`ifdef SEQ_DEBUG_HALT_EN
      ,
      .dbg_halt     (dbg_halt),
      .dbg_step     (dbg_step),
      .halted       (halted)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_state"}, 32'(state), 32'(STATE_RESET));
      chk({tag, "_cycle_count"}, 32'(cycle_count), 0);
      chk({tag, "_ir_load"}, 32'(ir_load), 0);
      chk({tag, "_pc_write"}, 32'(pc_write), 0);
      chk({tag, "_isr_take"}, 32'(isr_take), 0);
      chk({tag, "_retired"}, 32'(retired), 0);
   endtask

   // Called at a negedge with rst_n low; returns at the negedge showing the first IF.
   task automatic release_reset();
      int edges;
      edges = 0;
      chk_idle("in_reset");
      rst_n = 1'b1;
      for (int k = 1; k <= 20 && edges == 0; k++) begin
         @(negedge clk);
         if (state == STATE_IF) edges = k;
         else chk("reset_hold_state", 32'(state), 32'(STATE_RESET));
      end
      chk("reset_wait_cycles", 32'(edges), 32'(W));
      inj = 1'b0;
   endtask

   // Called at the negedge of IF; returns at the negedge of the following state.
   task automatic run_instr(input logic [OPCODE_COUNT-1:0] op, input logic irq_wb, input logic i_wb);
      logic two;
      int   n;
      logic [STATE_COUNT-1:0] es;
      two = (op == TYPE_RET) || (op == TYPE_RETI) || (op == TYPE_RCALL) || (op == TYPE_CALL_ISR);
      n = two ? 6 : 5;
      for (int j = 0; j < n; j++) begin
         if (j > 0) @(negedge clk);
         if (j == 0)          es = STATE_IF;
         else if (j == 1)     es = STATE_ID;
         else if (j == 2)     es = STATE_EX;
         else if (j == n - 1) es = STATE_WB;
         else                 es = STATE_MEM;
         chk("state", 32'(state), 32'(es));
         chk("cycle_count", 32'(cycle_count), 32'(two && j == 4));
         chk("ir_load", 32'(ir_load), 32'(j == 0 && !inj));
         chk("pc_write", 32'(pc_write), 32'(j == n - 1));
         chk("retired", 32'(retired), 32'(j == n - 1));
         chk("isr_take", 32'(isr_take), 32'(inj));
         if (j == 0) opcode_type = op;
         if (j == n - 1) begin
            irq_req = irq_wb;
            i_flag  = i_wb;
         end else begin
            irq_req = 1'($urandom);
            i_flag  = 1'($urandom);
         end
      end
      // One instruction always runs after RETI before an interrupt is accepted.
      inj = irq_wb && i_wb && (op != TYPE_RETI);
`ifdef SEQ_DEBUG_HALT_EN
      if (dbg_halt) inj = 1'b0;
`endif
      @(negedge clk);
   endtask

   initial begin
      logic [OPCODE_COUNT-1:0] op;
      ops[0] = TYPE_NOP;  ops[1] = TYPE_ADD;  ops[2] = TYPE_LDS;  ops[3] = TYPE_RJMP;
      ops[4] = TYPE_RET;  ops[5] = TYPE_RETI; ops[6] = TYPE_RCALL;

      repeat (3) @(negedge clk);
      release_reset();

      run_instr(TYPE_ADD, 1'b0, 1'b1);
      run_instr(TYPE_RET, 1'b0, 1'b0);
      run_instr(TYPE_ADD, 1'b1, 1'b1);
      chk("irq_taken_model", 32'(isr_take), 1);
      run_instr(TYPE_CALL_ISR, 1'b1, 1'b0);
      run_instr(TYPE_RETI, 1'b1, 1'b1);
      chk("after_reti_no_take", 32'(isr_take), 0);
      run_instr(TYPE_ADD, 1'b1, 1'b1);
      run_instr(TYPE_CALL_ISR, 1'b0, 1'b0);

      for (int k = 0; k < 60; k++) begin
         op = inj ? TYPE_CALL_ISR : ops[$urandom_range(0, 6)];
         run_instr(op, ($urandom_range(0, 2) == 0), 1'($urandom));
      end

      // Abort mid-MEM: clear any pending injection first with a quiet instruction.
      op = inj ? TYPE_CALL_ISR : TYPE_ADD;
      run_instr(op, 1'b0, 1'b0);
      opcode_type = TYPE_RET;
      repeat (4) @(negedge clk);
      chk("abort_pre_state", 32'(state), 32'(STATE_MEM));
      chk("abort_pre_cycle_count", 32'(cycle_count), 1);
      #2 rst_n = 1'b0;
      #1 chk_idle("abort");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_hold_pc_write", 32'(pc_write), 0);
      end
      release_reset();
      run_instr(TYPE_ADD, 1'b0, 1'b0);

`ifdef SEQ_DEBUG_HALT_EN
      dbg_halt = 1'b1;
      run_instr(TYPE_ADD, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk("halt_state", 32'(state), 32'(STATE_HALT));
         chk("halt_flag", 32'(halted), 1);
         chk("halt_retired", 32'(retired), 0);
         chk("halt_pc_write", 32'(pc_write), 0);
         @(negedge clk);
      end
      dbg_step = 1'b1;
      @(negedge clk);
      dbg_step = 1'b0;
      run_instr(TYPE_RET, 1'b0, 1'b0);
      chk("step_rehalt_state", 32'(state), 32'(STATE_HALT));
      chk("step_rehalt_flag", 32'(halted), 1);
      @(negedge clk);
      chk("step_stays_halted", 32'(halted), 1);
      dbg_halt = 1'b0;
      @(negedge clk);
      run_instr(TYPE_ADD, 1'b0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
